// File: rtl/rr_fifo_pop_arbiter_pkg.sv
// Shared definitions for the FIFO read-side round-robin arbiter and its picker.
package rr_fifo_pop_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    POP     = 2'b01,
    CAPTURE = 2'b10
  } arb_state_t;

  localparam int DEF_NUM_SRC   = 4;
  localparam int DEF_DATA_SIZE = 8;
  localparam int WORD_COUNT_W  = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requesting index searching upward
// from last_grant+1, wrapping modulo NUM_SRC (NUM_SRC is a power of two).
module rr_priority_picker
  import rr_fifo_pop_arbiter_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last_grant,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  logic [SEL_W-1:0] cand_s;
  logic             hit_s;

  // Scan candidates in priority order; the index add wraps naturally at SEL_W bits.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand_s = last_grant + SEL_W'(i);
      hit_s  = req[cand_s] & ~found;
      winner = hit_s ? cand_s : winner;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/rr_fifo_pop_arbiter.sv
// Round-robin read-side arbiter: pops one word at a time from non-empty source
// FIFOs and forwards it downstream with a one-cycle valid pulse.
module rr_fifo_pop_arbiter
  import rr_fifo_pop_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int SEL_W     = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*DATA_SIZE-1:0]  src_data,
  input  logic                          dst_pause,
  output logic [NUM_SRC-1:0]            src_pop,
  output logic [DATA_SIZE-1:0]          out_data,
  output logic                          out_valid,
  output logic [SEL_W-1:0]              active_src,
  output logic [WORD_COUNT_W-1:0]       word_count,
  output logic                          arb_error
);

  arb_state_t             state_r;
  arb_state_t             state_s;
  logic [SEL_W-1:0]       grant_r;
  logic [SEL_W-1:0]       grant_s;
  logic [SEL_W-1:0]       last_grant_r;
  logic [SEL_W-1:0]       last_grant_s;
  logic [SEL_W-1:0]       winner_s;
  logic                   found_s;
  logic                   arb_ok_s;
  logic                   arb_win_s;
  logic                   capture_s;
  logic                   err_s;
  logic                   grant_empty_s;
  logic [DATA_SIZE-1:0]   src_word_s;

  rr_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_picker (
    .req        (~src_empty),
    .last_grant (last_grant_r),
    .winner     (winner_s),
    .found      (found_s)
  );

  // Pause only gates new arbitration; a grant already in POP always completes.
  assign arb_ok_s      = found_s & ~dst_pause;
  assign grant_empty_s = src_empty[grant_r];
  assign src_word_s    = src_data[grant_r*DATA_SIZE +: DATA_SIZE];

  // Next-state and arbitration decode.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    arb_win_s    = 1'b0;
    capture_s    = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_ok_s) begin
          arb_win_s    = 1'b1;
          grant_s      = winner_s;
          last_grant_s = winner_s;
          state_s      = POP;
        end else begin
          state_s      = IDLE;
        end
      end
      POP: begin
        if (grant_empty_s) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = CAPTURE;
        end
      end
      CAPTURE: begin
        capture_s = 1'b1;
        if (arb_ok_s) begin
          arb_win_s    = 1'b1;
          grant_s      = winner_s;
          last_grant_s = winner_s;
          state_s      = POP;
        end else begin
          state_s      = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Pop strobe: only from POP, only if the granted FIFO still holds data, never in reset.
  always_comb begin
    src_pop = '0;
    if (reset && (state_r == POP) && !grant_empty_s) begin
      src_pop = {{(NUM_SRC-1){1'b0}}, 1'b1} << grant_r;
    end else begin
      src_pop = '0;
    end
  end

  // State, grant bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_grant_r <= SEL_W'(NUM_SRC - 1);
      active_src   <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      word_count   <= '0;
      arb_error    <= 1'b0;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      active_src   <= arb_win_s ? winner_s : active_src;
      out_valid    <= capture_s;
      arb_error    <= err_s;
      if (capture_s) begin
        out_data   <= src_word_s;
        word_count <= word_count + WORD_COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_fifo_pop_arbiter.sv
// Self-checking bench: behavioural source FIFOs, a vector table, directed
// corner sequences and a randomized run against a round-robin scoreboard.
module tb_rr_fifo_pop_arbiter;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int LOGN = 64;

  logic              clk;
  logic              reset;
  logic [NS-1:0]     src_empty;
  logic [NS*DW-1:0]  src_data;
  logic              dst_pause;
  logic [NS-1:0]     src_pop;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [1:0]        active_src;
  logic [15:0]       word_count;
  logic              arb_error;

  rr_fifo_pop_arbiter #(.DATA_SIZE(DW), .NUM_SRC(NS)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_empty  (src_empty),
    .src_data   (src_data),
    .dst_pause  (dst_pause),
    .src_pop    (src_pop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .active_src (active_src),
    .word_count (word_count),
    .arb_error  (arb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic          reset_v;
  logic          pause_v;
  logic [NS-1:0] force_mask;
  logic [NS-1:0] pop_seen;
  logic [NS-1:0] last_req;
  logic          last_pause;
  logic [7:0]    fifo [NS][$];

  logic [NS-1:0] s_pop;
  logic          s_valid;
  logic [7:0]    s_data;
  logic [1:0]    s_active;
  logic [15:0]   s_wc;
  logic          s_err;

  logic [NS-1:0] log_pop   [LOGN];
  logic          log_valid [LOGN];
  logic [7:0]    log_data  [LOGN];
  logic [1:0]    log_active[LOGN];
  logic [15:0]   log_wc    [LOGN];
  logic          log_err   [LOGN];

  typedef struct packed {
    logic [3:0]  pop;
    logic        valid;
    logic [7:0]  data;
    logic [1:0]  active;
    logic [15:0] wc;
  } vec_t;
  vec_t tbl [12];

  // scoreboard state for the randomized run
  int          m_last;
  int          m_count;
  logic [7:0]  exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: FIFOs react to the pop seen last cycle, new inputs applied,
  // outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (pop_seen[i] && fifo[i].size() > 0) src_data[i*DW +: DW] = fifo[i].pop_front();
    end
    last_req   = ~src_empty;
    last_pause = dst_pause;
    for (int i = 0; i < NS; i++) src_empty[i] = (fifo[i].size() == 0) || force_mask[i];
    dst_pause = pause_v;
    reset     = reset_v;
    @(negedge clk);
    s_pop = src_pop; s_valid = out_valid; s_data = out_data;
    s_active = active_src; s_wc = word_count; s_err = arb_error;
    pop_seen = src_pop;
    if (cyc >= 0 && cyc < LOGN) begin
      log_pop[cyc] = s_pop; log_valid[cyc] = s_valid; log_data[cyc] = s_data;
      log_active[cyc] = s_active; log_wc[cyc] = s_wc; log_err[cyc] = s_err;
    end
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NS; i++) fifo[i].delete();
    reset_v = 1'b0; pause_v = 1'b0; force_mask = '0;
    cyc = -2;
    tick();
    tick();
    reset_v = 1'b1;
    cyc = 0;
  endtask

  // Round-robin scoreboard: each pop must be the rule's winner from the
  // previous cycle's requests; each valid must deliver the oldest popped word.
  task automatic score();
    int win;
    if (s_pop != '0) begin
      chk("rand_pop_onehot", $countones(s_pop), 1);
      chk("rand_pop_while_paused", last_pause, 0);
      win = -1;
      for (int k = 1; k <= NS; k++) begin
        if (win < 0 && last_req[(m_last + k) % NS]) win = (m_last + k) % NS;
      end
      chk("rand_pop_winner", s_pop, (win >= 0) ? (1 << win) : 0);
      if (win >= 0 && fifo[win].size() > 0) begin
        m_last = win;
        exp_q.push_back(fifo[win][0]);
      end
    end
    if (s_valid) begin
      if (exp_q.size() == 0) begin
        chk("rand_spurious_valid", 1, 0);
      end else begin
        m_count++;
        chk("rand_out_data", s_data, exp_q.pop_front());
        chk("rand_word_count", s_wc, m_count & 16'hFFFF);
      end
    end
    chk("rand_arb_error", s_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int remaining;
    reset = 1'b0; src_empty = '1; src_data = '0; dst_pause = 1'b0;
    pop_seen = '0; force_mask = '0; last_req = '0; last_pause = 1'b0;
    reset_v = 1'b0; pause_v = 1'b0; cyc = 0;

    // reset state
    do_reset();
    chk("rst_out_valid", s_valid, 0);
    chk("rst_out_data", s_data, 0);
    chk("rst_active_src", s_active, 0);
    chk("rst_word_count", s_wc, 0);
    chk("rst_arb_error", s_err, 0);
    chk("rst_src_pop", s_pop, 0);

    // vector table: all four sources loaded with two words each
    tbl[0]  = {4'b0000, 1'b0, 8'h00, 2'd0, 16'd0};
    tbl[1]  = {4'b0001, 1'b0, 8'h00, 2'd0, 16'd0};
    tbl[2]  = {4'b0000, 1'b0, 8'h00, 2'd0, 16'd0};
    tbl[3]  = {4'b0010, 1'b1, 8'h10, 2'd1, 16'd1};
    tbl[4]  = {4'b0000, 1'b0, 8'h10, 2'd1, 16'd1};
    tbl[5]  = {4'b0100, 1'b1, 8'h20, 2'd2, 16'd2};
    tbl[6]  = {4'b0000, 1'b0, 8'h20, 2'd2, 16'd2};
    tbl[7]  = {4'b1000, 1'b1, 8'h30, 2'd3, 16'd3};
    tbl[8]  = {4'b0000, 1'b0, 8'h30, 2'd3, 16'd3};
    tbl[9]  = {4'b0001, 1'b1, 8'h40, 2'd0, 16'd4};
    tbl[10] = {4'b0000, 1'b0, 8'h40, 2'd0, 16'd4};
    tbl[11] = {4'b0010, 1'b1, 8'h11, 2'd1, 16'd5};
    do_reset();
    for (int i = 0; i < NS; i++) begin
      fifo[i].push_back(8'((i + 1) * 16));
      fifo[i].push_back(8'((i + 1) * 16 + 1));
    end
    repeat (12) tick();
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("tbl_pop[%0d]", c), log_pop[c], tbl[c].pop);
      chk($sformatf("tbl_valid[%0d]", c), log_valid[c], tbl[c].valid);
      chk($sformatf("tbl_data[%0d]", c), log_data[c], tbl[c].data);
      chk($sformatf("tbl_active[%0d]", c), log_active[c], tbl[c].active);
      chk($sformatf("tbl_wc[%0d]", c), log_wc[c], tbl[c].wc);
    end

    // single source: three words from source 2
    do_reset();
    fifo[2] = '{8'hA1, 8'hB2, 8'hC3};
    repeat (12) tick();
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("single_pop[%0d]", c), log_pop[c],
          (c == 1 || c == 3 || c == 5) ? 4'b0100 : 4'b0000);
      chk($sformatf("single_valid[%0d]", c), log_valid[c], (c == 3 || c == 5 || c == 7) ? 1 : 0);
    end
    chk("single_data0", log_data[3], 8'hA1);
    chk("single_data1", log_data[5], 8'hB2);
    chk("single_data2", log_data[7], 8'hC3);
    chk("single_word_count", s_wc, 3);
    chk("single_active_src", s_active, 2);

    // pause raised during POP: word still delivered, then no pops until released
    do_reset();
    fifo[0] = '{8'h51, 8'h52};
    fifo[1] = '{8'h61};
    tick();
    pause_v = 1'b1;
    repeat (8) tick();
    pause_v = 1'b0;
    repeat (6) tick();
    chk("pause_pop_completes", log_pop[1], 4'b0001);
    chk("pause_valid", log_valid[3], 1);
    chk("pause_data", log_data[3], 8'h51);
    remaining = 0;
    for (int c = 2; c < 10; c++) remaining += int'(log_pop[c] != 4'b0000);
    chk("pause_no_pops", remaining, 0);
    chk("pause_resume_pop", log_pop[10], 4'b0010);
    chk("pause_resume_data", log_data[12], 8'h61);
    chk("pause_resume_valid", log_valid[12], 1);

    // empty race: granted FIFO reads empty during POP
    do_reset();
    fifo[0] = '{8'h77};
    tick();
    force_mask = 4'b0001;
    tick();
    force_mask = '0;
    repeat (6) tick();
    chk("race_pop_suppressed", log_pop[1], 4'b0000);
    chk("race_err_pulse", log_err[2], 1);
    chk("race_err_once", int'(log_err[1]) + int'(log_err[3]) + int'(log_err[4]), 0);
    chk("race_no_valid", int'(log_valid[2]) + int'(log_valid[3]) + int'(log_valid[4]), 0);
    chk("race_idle_wc", log_wc[4], 0);
    chk("race_retry_pop", log_pop[3], 4'b0001);
    chk("race_retry_data", log_data[5], 8'h77);

    // reset asserted in the CAPTURE cycle
    do_reset();
    fifo[0] = '{8'h81, 8'h82};
    fifo[1] = '{8'h91};
    tick();
    tick();
    reset_v = 1'b0;
    tick();
    reset_v = 1'b1;
    repeat (6) tick();
    chk("rstmid_pop", log_pop[1], 4'b0001);
    chk("rstmid_valid", int'(log_valid[2]) + int'(log_valid[3]), 0);
    chk("rstmid_data", log_data[3], 0);
    chk("rstmid_active", log_active[3], 0);
    chk("rstmid_wc", log_wc[3], 0);
    chk("rstmid_next_grant", log_pop[4], 4'b0001);
    chk("rstmid_next_data", log_data[6], 8'h82);

    // reset asserted in the POP cycle gates the strobe
    do_reset();
    fifo[1] = '{8'hE1};
    tick();
    reset_v = 1'b0;
    tick();
    reset_v = 1'b1;
    repeat (5) tick();
    chk("rstpop_gated", log_pop[1], 4'b0000);
    chk("rstpop_regrant", log_pop[3], 4'b0010);
    chk("rstpop_data", log_data[5], 8'hE1);

    // counter wrap
    do_reset();
    tick();
    force dut.word_count = 16'hFFFF;
    tick();
    release dut.word_count;
    tick();
    chk("wrap_preload", s_wc, 16'hFFFF);
    fifo[3] = '{8'h3C};
    repeat (5) tick();
    chk("wrap_valid", log_valid[6], 1);
    chk("wrap_data", log_data[6], 8'h3C);
    chk("wrap_word_count", log_wc[6], 0);

    // randomized traffic with random pause
    do_reset();
    m_last = NS - 1;
    m_count = 0;
    exp_q.delete();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 99) < 20 && fifo[i].size() < 6) fifo[i].push_back(8'($urandom));
      end
      pause_v = ($urandom_range(0, 99) < 25);
      tick();
      score();
    end
    pause_v = 1'b0;
    for (int t = 0; t < 200; t++) begin
      remaining = exp_q.size();
      for (int i = 0; i < NS; i++) remaining += fifo[i].size();
      if (remaining == 0) break;
      tick();
      score();
    end
    remaining = exp_q.size();
    for (int i = 0; i < NS; i++) remaining += fifo[i].size();
    chk("rand_drained", remaining, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
